// File: rtl/sequence_checker.sv
// Checks an incrementing (mod 2^WIDTH) word stream: acquires lock, then counts
// mismatches, checked words and all-ones->zero wraps with saturating counters.
module sequence_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear,
  output logic             locked,
  output logic             error_pulse,
  output logic [CNT_W-1:0] error_count,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int unsigned RUN_W = 8;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic [RUN_W-1:0]   good_run_q, good_run_d;
  logic [RUN_W-1:0]   bad_run_q, bad_run_d;
  logic               error_pulse_q, error_pulse_d;
  logic [CNT_W-1:0]   error_count_q, error_count_d;
  logic [CNT_W-1:0]   word_count_q, word_count_d;
  logic [CNT_W-1:0]   wrap_count_q, wrap_count_d;

  logic [WIDTH-1:0]   prev_inc;
  logic               match;
  logic               wrap;
  logic [RUN_W-1:0]   good_inc;
  logic [RUN_W-1:0]   bad_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    prev_inc = prev_q + WIDTH'(1);
    match    = have_prev_q && (data_in == prev_inc);
    wrap     = match && (prev_q == '1) && (data_in == '0);
    good_inc = good_run_q + RUN_W'(1);
    bad_inc  = bad_run_q + RUN_W'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SEARCH;
      prev_q        <= '0;
      have_prev_q   <= 1'b0;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      error_pulse_q <= 1'b0;
      error_count_q <= '0;
      word_count_q  <= '0;
      wrap_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      have_prev_q   <= have_prev_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      error_pulse_q <= error_pulse_d;
      error_count_q <= error_count_d;
      word_count_q  <= word_count_d;
      wrap_count_q  <= wrap_count_d;
    end
  end

  // Next state: lock acquisition / loss and resync of the previous word
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    if (data_valid) begin
      prev_d      = data_in;
      have_prev_d = 1'b1;
      case (state_q)
        SEARCH: begin
          if (!match) begin
            good_run_d = '0;
          end else if (good_inc == RUN_W'(LOCK_COUNT)) begin
            state_d    = LOCKED;
            good_run_d = '0;
          end else begin
            good_run_d = good_inc;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_run_d = '0;
          end else if (bad_inc == RUN_W'(LOSS_COUNT)) begin
            state_d     = SEARCH;
            bad_run_d   = '0;
            have_prev_d = 1'b0;
          end else begin
            bad_run_d = bad_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Outputs: statistics only move while locked; clear wins over increments
  always_comb begin
    error_pulse_d = 1'b0;
    error_count_d = error_count_q;
    word_count_d  = word_count_q;
    wrap_count_d  = wrap_count_q;
    if (data_valid && (state_q == LOCKED)) begin
      word_count_d = sat_inc(word_count_q);
      if (!match) begin
        error_pulse_d = 1'b1;
        error_count_d = sat_inc(error_count_q);
      end else if (wrap) begin
        wrap_count_d = sat_inc(wrap_count_q);
      end
    end
    if (clear) begin
      error_count_d = '0;
      word_count_d  = '0;
      wrap_count_d  = '0;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign error_pulse = error_pulse_q;
  assign error_count = error_count_q;
  assign word_count  = word_count_q;
  assign wrap_count  = wrap_count_q;

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Downstream consumer of the incrementing test-pattern source. Samples the 8-bit stream and checks that each valid word equals the previous word + 1, modulo 2^WIDTH, so 0xFF is followed by 0x00.
- Acquires lock on the pattern, then counts errors, checked words and wrap events for loop-integrity reporting.
- Sits at the end of the data loop, after the source and any transport stages.

Parameters:
- WIDTH, 8, data word width.
- LOCK_COUNT, 4, consecutive matching transitions required to enter LOCKED (legal range 1..255).
- LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop back to SEARCH (legal range 1..255).
- CNT_W, 16, width of error_count, word_count and wrap_count.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- data_valid  input  1  data_in is sampled this cycle when high.
- data_in  input  WIDTH  pattern word from upstream.
- clear  input  1  synchronous clear of the statistics counters; does not affect lock state.
- locked  output  1  high while the state machine is in LOCKED.
- error_pulse  output  1  one-cycle pulse per mismatch detected in LOCKED.
- error_count  output  CNT_W  mismatches detected in LOCKED; saturating.
- word_count  output  CNT_W  valid words checked in LOCKED, matches and mismatches; saturating.
- wrap_count  output  CNT_W  matching 0xFF->0x00 (all-ones->zero) transitions in LOCKED; saturating.

Behaviour:
- Reset (reset == 0 at a clock edge):
  - state = SEARCH; locked = 0, error_pulse = 0, all counters = 0.
  - prev register = 0; have_prev = 0; good_run = 0; bad_run = 0.
  - Applies at any time, including mid-lock or mid-error; the first edge with reset high resumes in SEARCH.
- Compare rule: match = have_prev && (data_in == prev + 1, truncated to WIDTH bits).
- Every valid cycle: prev <= data_in and have_prev <= 1, so the checker resyncs to the received value. A single corrupted word therefore yields 2 mismatches.
- data_valid low: no state, counter or prev change; error_pulse = 0. Gaps of any length do not break the sequence.
- SEARCH state:
  - First valid word after reset, or after entry from LOCKED, only captures prev. have_prev is cleared on the LOCKED->SEARCH transition.
  - Each valid match: good_run++. A valid mismatch sets good_run = 0.
  - When a match makes good_run reach LOCK_COUNT: next state = LOCKED and good_run = 0. The lock-completing word is not counted.
  - No error_pulse and no counter updates in SEARCH.
- LOCKED state, each valid word:
  - word_count++.
  - Match: bad_run = 0. If prev is all-ones and data_in is 0, wrap_count++.
  - Mismatch: error_pulse = 1 on the following cycle, error_count++ and bad_run++.
  - When bad_run reaches LOSS_COUNT: next state = SEARCH, bad_run = 0, have_prev = 0.
- Latency: all outputs are registered and reflect the word sampled on edge N from edge N (visible in cycle N+1). locked rises in the cycle after the lock-completing word.
- Saturation: counters hold at all-ones and never wrap.
- clear:
  - Zeroes error_count, word_count and wrap_count on the next edge.
  - Has priority over a simultaneous increment: the result is 0, but error_pulse still asserts for a mismatch that cycle.
  - State, prev and the run counters are unaffected.
- Reset has priority over clear and data_valid.

Test Plan:
- Reset, then 0x00..0x0A continuous with valid=1 -> locked rises the cycle after word 0x04 (first word captures, 4 matches); error_count = 0; word_count = 6 after 0x0A.
- Locked stream 0xF0..0xFF,0x00..0x05 -> wrap_count = 1, error_count = 0, no error_pulse.
- Locked at 0x10, inject 0x55 in place of 0x11, then 0x12,0x13 -> two error_pulses (0x55 and 0x12), error_count = 2, locked stays 1, bad_run recovers at 0x13.
- Locked, then 3 consecutive mismatching words (0x20,0x40,0x60) -> locked falls the cycle after 0x60; 0x61..0x65 relocks after 0x65; counters retain values.
- Valid toggled 1/0 every cycle over 0x00..0x08, then clear asserted in the same cycle as a mismatch -> lock still achieved with gaps; after clear, all three counters = 0 and error_pulse = 1.
- Locked mid-stream, assert reset=0 for one edge -> next cycle locked = 0, all counters = 0; error_count saturation checked with CNT_W = 4 overridden: 20 mismatches -> error_count = 15.
